regfile_operand_stage: RTL and testbench

//  - Register file plus operand-issue stage sitting directly upstream of the 16-bit shifter.
//  - Holds NREGS general-purpose registers and reads two of them per request: A and B.
//  - Latches A, B and a 2-bit shift code into output registers under a valid/ready handshake.
//  - op_b/op_shift feed the shifter's in/shift; op_a goes to the ALU A input.

---
 rtl/regfile_operand_stage.sv | 113 +++++++++++
 tb/tb_regfile_operand_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_stage.sv
// Register file with a one-entry operand-issue pipeline register feeding the shifter/ALU.
// Optional build macro REGFILE_BYPASS_EN: same-index read-during-write returns wr_data.
module regfile_operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [1:0]        shift_in,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        op_shift,
  output logic [7:0]        rd_count
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [1:0]        op_shift_q, op_shift_d;
  logic [7:0]        rd_count_q, rd_count_d;
  logic [DATA_W-1:0] rd_a_s, rd_b_s;
  logic              rd_ready_s, accept_s;

  assign rd_ready_s = !op_valid_q || op_ready;
  assign accept_s   = rd_valid && rd_ready_s;

  // Operand read ports, optionally forwarding a same-cycle write to the same index.
  always_comb begin
    rd_a_s = regs_q[rd_addr_a];
    rd_b_s = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_a_s = wr_data;
    end else begin
      rd_a_s = regs_q[rd_addr_a];
    end
    if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_b_s = wr_data;
    end else begin
      rd_b_s = regs_q[rd_addr_b];
    end
`endif
  end

  // Issue-register next state: load on accept, drain on consume, otherwise hold.
  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_shift_d = op_shift_q;
    rd_count_d = rd_count_q;
    if (accept_s) begin
      op_valid_d = 1'b1;
      op_a_d     = rd_a_s;
      op_b_d     = rd_b_s;
      op_shift_d = shift_in;
      rd_count_d = rd_count_q + 8'd1;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end else begin
      op_valid_d = op_valid_q;
    end
  end

  // Register array; writes are unconditional on wr_en and ignore the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end else begin
      regs_q[wr_addr] <= regs_q[wr_addr];
    end
  end

  // Issue-stage state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_shift_q <= 2'b00;
      rd_count_q <= 8'd0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_shift_q <= op_shift_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_ready = rd_ready_s;
  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_shift = op_shift_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all cross-checked every cycle against a behavioural register-file model.
module tb_regfile_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [1:0]  shift_in;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic [1:0]  op_shift;
  logic [7:0]  rd_count;

  int checks = 0;
  int errors = 0;

  regfile_operand_stage #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .shift_in(shift_in),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_shift(op_shift), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: an array of registers and the pending operand bundle.
  logic [15:0] m_regs [8];
  logic        m_valid;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_shift;
  logic [7:0]  m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_valid = 1'b0; m_a = 16'h0000; m_b = 16'h0000; m_shift = 2'b00; m_cnt = 8'd0;
    end else begin
      logic [15:0] va, vb;
      va = m_regs[rd_addr_a];
      vb = m_regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rd_addr_a) va = wr_data;
      if (wr_en && wr_addr == rd_addr_b) vb = wr_data;
`endif
      if (rd_valid && (!m_valid || op_ready)) begin
        m_valid = 1'b1; m_a = va; m_b = vb; m_shift = shift_in; m_cnt = m_cnt + 8'd1;
      end else if (op_ready) begin
        m_valid = 1'b0;
      end
      if (wr_en) m_regs[wr_addr] = wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    check("cmp_rd_ready", {31'd0, rd_ready}, {31'd0, (!m_valid || op_ready)});
    check("cmp_op_a", {16'd0, op_a}, {16'd0, m_a});
    check("cmp_op_b", {16'd0, op_b}, {16'd0, m_b});
    check("cmp_op_shift", {30'd0, op_shift}, {30'd0, m_shift});
    check("cmp_rd_count", {24'd0, rd_count}, {24'd0, m_cnt});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_valid = 1'b0; op_ready = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic req(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    rd_valid = 1'b1; rd_addr_a = a; rd_addr_b = b; shift_in = s;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    rd_valid = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0; shift_in = 2'b00; op_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_op_valid", {31'd0, op_valid}, 32'd0);
    check("reset_rd_count", {24'd0, rd_count}, 32'd0);
    check("reset_rd_ready", {31'd0, rd_ready}, 32'd1);

    // Write then read two registers.
    wr(3'd2, 16'h1234); tick();
    wr(3'd7, 16'hF00F); tick();
    wr_en = 1'b0; op_ready = 1'b0; req(3'd2, 3'd7, 2'b11); tick();
    check("wr_rd_valid", {31'd0, op_valid}, 32'd1);
    check("wr_rd_a", {16'd0, op_a}, 32'h1234);
    check("wr_rd_b", {16'd0, op_b}, 32'hF00F);
    check("wr_rd_shift", {30'd0, op_shift}, 32'd3);

    // Stall with a write to the source register and a pending request.
    req(3'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      wr(3'd2, 16'hAAAA);
      check("stall_rd_ready", {31'd0, rd_ready}, 32'd0);
      tick();
      check("stall_op_a", {16'd0, op_a}, 32'h1234);
    end
    idle(); tick();
    check("drain_op_valid", {31'd0, op_valid}, 32'd0);
    check("drain_count", {24'd0, rd_count}, 32'd1);

    // Reset mid-stream with op_valid high.
    req(3'd2, 3'd7, 2'b10); tick();
    rd_valid = 1'b0;
    check("pre_reset_valid", {31'd0, op_valid}, 32'd1);
    reset = 1'b1; #1;
    check("async_reset_valid", {31'd0, op_valid}, 32'd0);
    check("async_reset_a", {16'd0, op_a}, 32'd0);
    check("async_reset_b", {16'd0, op_b}, 32'd0);
    check("async_reset_count", {24'd0, rd_count}, 32'd0);
    tick(); reset = 1'b0;
    req(3'd5, 3'd2, 2'b00); tick(); rd_valid = 1'b0;
    check("post_reset_r5", {16'd0, op_a}, 32'h0000);
    check("post_reset_r2", {16'd0, op_b}, 32'h0000);

    // Throughput from a clean count, then wrap of the 8-bit counter.
    reset = 1'b1; tick(); reset = 1'b0; idle();
    for (int i = 0; i < 10; i++) begin
      req(3'($urandom_range(7)), 3'($urandom_range(7)), 2'($urandom_range(3)));
      tick();
      check("tput_valid", {31'd0, op_valid}, 32'd1);
    end
    rd_valid = 1'b0; tick();
    check("tput_count", {24'd0, rd_count}, 32'd10);
    rd_valid = 1'b1;
    for (int i = 0; i < 245; i++) tick();
    rd_valid = 1'b0; tick();
    check("count_255", {24'd0, rd_count}, 32'd255);
    rd_valid = 1'b1; tick(); rd_valid = 1'b0;
    check("count_wrap", {24'd0, rd_count}, 32'd0);

    // Read-during-write on the same index.
    wr(3'd3, 16'h0001); tick();
    wr(3'd3, 16'h00FF); req(3'd3, 3'd3, 2'b01); tick();
    wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    check("rdw_a", {16'd0, op_a}, 32'h00FF);
    check("rdw_b", {16'd0, op_b}, 32'h00FF);
`else
    check("rdw_a", {16'd0, op_a}, 32'h0001);
    check("rdw_b", {16'd0, op_b}, 32'h0001);
`endif
    req(3'd3, 3'd0, 2'b00); tick(); rd_valid = 1'b0;
    check("rdw_after", {16'd0, op_a}, 32'h00FF);

    // Same index on both operands.
    wr(3'd7, 16'h8001); tick(); wr_en = 1'b0;
    req(3'd7, 3'd7, 2'b10); tick(); rd_valid = 1'b0;
    check("same_a", {16'd0, op_a}, 32'h8001);
    check("same_b", {16'd0, op_b}, 32'h8001);

    // Randomized traffic, checked by the per-cycle compare against the model.
    for (int i = 0; i < 400; i++) begin
      wr_en    = 1'($urandom_range(1));
      wr_addr  = 3'($urandom_range(7));
      wr_data  = 16'($urandom);
      rd_valid = ($urandom_range(3) != 0);
      rd_addr_a = 3'($urandom_range(7));
      rd_addr_b = 3'($urandom_range(7));
      shift_in = 2'($urandom_range(3));
      op_ready = ($urandom_range(2) != 0);
      tick();
    end
    idle(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
